// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle for clk_div_ctrl.
// Carries the half-period request and its ready/error responses.
interface clk_div_ctrl_if #(
   parameter int unsigned COUNT_W = 25
);
   logic               i_cfg_valid;
   logic [COUNT_W-1:0] i_cfg_half;
   logic               o_cfg_ready;
   logic               o_cfg_err;

   modport master (
      output i_cfg_valid,
      output i_cfg_half,
      input  o_cfg_ready,
      input  o_cfg_err
   );

   modport slave (
      input  i_cfg_valid,
      input  i_cfg_half,
      output o_cfg_ready,
      output o_cfg_err
   );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time controller for a glitch-free programmable clock divider.
// Optional auto-stop after N periods: define CLK_DIV_CTRL_BURST_EN.
module clk_div_ctrl #(
   parameter int unsigned COUNT_W      = 25,
   parameter int unsigned DEFAULT_HALF = 12_500_000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic        i_stop,
`ifdef CLK_DIV_CTRL_BURST_EN
   input  logic [15:0] i_burst_len,
`endif
   clk_div_ctrl_if.slave cfg,
   output logic        o_clk,
   output logic        o_tick,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STOP
   } state_e;

   state_e             state_q, state_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic [COUNT_W-1:0] half_q, half_d;
   logic [COUNT_W-1:0] pend_q, pend_d;
   logic               pend_vld_q, pend_vld_d;
   logic               clk_q, clk_d;
   logic               tick_q, tick_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic xfer;
   logic take;
   logic hit;
   logic fall;
   logic go;
   logic last;
   logic apply;

   assign xfer = cfg.i_cfg_valid & ~pend_vld_q;
   assign take = xfer & (cfg.i_cfg_half != '0);
   assign hit  = (cnt_q == (half_q - COUNT_W'(1)));
   assign fall = hit & clk_q;
   assign go   = i_start & ~i_stop;

`ifdef CLK_DIV_CTRL_BURST_EN
   logic [15:0] blen_q, blen_d;
   logic [15:0] per_q, per_d;

   assign last = (blen_q != 16'd0) & (per_q == blen_q - 16'd1);

   always_comb begin
      blen_d = blen_q;
      per_d  = per_q;
      if (state_q == S_IDLE && go) begin
         blen_d = i_burst_len;
         per_d  = 16'd0;
      end else if (state_q != S_IDLE && fall) begin
         per_d = per_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         blen_q <= 16'd0;
         per_q  <= 16'd0;
      end else begin
         blen_q <= blen_d;
         per_q  <= per_d;
      end
   end
`else
   assign last = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      half_d     = half_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      clk_d      = clk_q;
      err_d      = 1'b0;
      apply      = 1'b0;

      if (xfer && !take) begin
         err_d = 1'b1;
      end else if (take && state_q == S_IDLE) begin
         half_d = cfg.i_cfg_half;
      end else if (take) begin
         pend_d     = cfg.i_cfg_half;
         pend_vld_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            clk_d = 1'b0;
            cnt_d = '0;
            if (go) state_d = S_RUN;
         end
         S_RUN, S_STOP: begin
            if (hit) begin
               cnt_d = '0;
               clk_d = ~clk_q;
            end else begin
               cnt_d = cnt_q + COUNT_W'(1);
            end
            // a stop in the low phase may cut it short; a high phase never
            if (state_q == S_RUN && i_stop && !clk_q) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               clk_d   = 1'b0;
               apply   = 1'b1;
            end else if (fall) begin
               apply = 1'b1;
               if (state_q == S_STOP || i_stop || last)
                  state_d = S_IDLE;
            end else if (state_q == S_RUN && i_stop) begin
               state_d = S_STOP;
            end else if (state_q == S_STOP && go) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
         end
      endcase

      // a request landing on the boundary itself is applied at once
      if (apply) begin
         if (pend_vld_q) half_d = pend_q;
         else if (take)  half_d = cfg.i_cfg_half;
         pend_vld_d = 1'b0;
      end
   end

   assign tick_d = clk_d & ~clk_q;
   assign busy_d = (state_d != S_IDLE);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         half_q     <= COUNT_W'(DEFAULT_HALF);
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         clk_q      <= 1'b0;
         tick_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         half_q     <= half_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         clk_q      <= clk_d;
         tick_q     <= tick_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   assign o_clk           = clk_q;
   assign o_tick          = tick_q;
   assign o_busy          = busy_q;
   assign cfg.o_cfg_ready = ~pend_vld_q;
   assign cfg.o_cfg_err   = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl with DEFAULT_HALF shrunk to 4.
// Burst checks are compiled in when CLK_DIV_CTRL_BURST_EN is defined.
module tb_clk_div_ctrl;

   localparam int unsigned CW = 25;

   typedef struct {
      logic          st;
      logic          sp;
      logic          cv;
      logic [CW-1:0] ch;
      int            n;
      logic          c;
      logic          t;
      logic          b;
      logic          r;
      logic          e;
   } vec_t;

   typedef struct {
      logic c;
      logic t;
      logic b;
      logic r;
      logic e;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic [15:0] blen;
   logic        o_clk;
   logic        o_tick;
   logic        o_busy;

   int n_chk;
   int n_fail;
   int cyc;

   vec_t vecs[$];
   exp_t sb[$];

   clk_div_ctrl_if #(.COUNT_W(CW)) cfg_if ();

   clk_div_ctrl #(
      .COUNT_W     (CW),
      .DEFAULT_HALF(4)
   ) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_start    (start),
      .i_stop     (stop),
`ifdef CLK_DIV_CTRL_BURST_EN
      .i_burst_len(blen),
`endif
      .cfg        (cfg_if),
      .o_clk      (o_clk),
      .o_tick     (o_tick),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
      end
   endtask

   task automatic chk_all(input exp_t e);
      chk("o_clk", o_clk, e.c);
      chk("o_tick", o_tick, e.t);
      chk("o_busy", o_busy, e.b);
      chk("o_cfg_ready", cfg_if.o_cfg_ready, e.r);
      chk("o_cfg_err", cfg_if.o_cfg_err, e.e);
   endtask

   task automatic v(input logic st, input logic sp, input logic cv,
                    input logic [CW-1:0] ch, input int n,
                    input logic c, input logic t, input logic b,
                    input logic r, input logic e);
      vec_t x;
      x.st = st; x.sp = sp; x.cv = cv; x.ch = ch; x.n = n;
      x.c = c; x.t = t; x.b = b; x.r = r; x.e = e;
      vecs.push_back(x);
   endtask

   task automatic idle_inputs();
      start = 1'b0;
      stop  = 1'b0;
      cfg_if.i_cfg_valid = 1'b0;
      cfg_if.i_cfg_half  = '0;
   endtask

   task automatic run_vecs();
      exp_t e;
      foreach (vecs[i]) begin
         for (int k = 0; k < vecs[i].n; k++) begin
            @(negedge clk);
            start = vecs[i].st;
            stop  = vecs[i].sp;
            cfg_if.i_cfg_valid = vecs[i].cv;
            cfg_if.i_cfg_half  = vecs[i].ch;
            e.c = vecs[i].c; e.t = vecs[i].t; e.b = vecs[i].b;
            e.r = vecs[i].r; e.e = vecs[i].e;
            sb.push_back(e);
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            chk_all(e);
         end
      end
      vecs.delete();
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      exp_t rv;
      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      blen   = 16'd0;
      rst_n  = 1'b0;
      idle_inputs();
      rv.c = 1'b0; rv.t = 1'b0; rv.b = 1'b0; rv.r = 1'b1; rv.e = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk_all(rv);
      @(negedge clk);
      rst_n = 1'b1;

      //  st sp cv half  n   clk tk bsy rdy err
      v(1, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 3,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 0, 0, 0, 3,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 1, 3, 1,   0, 0, 1, 0, 0);
      v(0, 0, 0, 0, 2,   0, 0, 1, 0, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 0, 0);
      v(0, 0, 0, 0, 3,   1, 0, 1, 0, 0);
      v(0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 2,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 0, 0, 0, 2,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 3,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 1, 0, 0, 1,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
      v(0, 0, 1, 0, 1,   0, 0, 0, 1, 1);
      v(1, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 2,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(1, 1, 0, 0, 1,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
      v(0, 0, 1, 5, 1,   0, 0, 0, 1, 0);
      v(1, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 4,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 1, 0, 0, 1,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 3,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
      v(1, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 1, 0, 0, 1,   0, 0, 0, 1, 0);
      v(1, 1, 0, 0, 1,   0, 0, 0, 1, 0);
      v(0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
      v(1, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 4,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 1, 0, 0, 1,   1, 0, 1, 1, 0);
      v(1, 0, 0, 0, 1,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 2,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 4,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 0, 1, 2, 1,   1, 0, 1, 0, 0);
      run_vecs();

      // asynchronous reset mid-run with a pending half of 2
      #2;
      rst_n = 1'b0;
      #1;
      chk_all(rv);
      @(posedge clk);
      #1;
      chk_all(rv);
      @(negedge clk);
      rst_n = 1'b1;

      // default half 4 must be back in force
      v(1, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 3,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 0, 0, 0, 3,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 1, 0, 0, 1,   0, 0, 0, 1, 0);
      run_vecs();

`ifdef CLK_DIV_CTRL_BURST_EN
      blen = 16'd3;
      v(0, 0, 1, 2, 1,   0, 0, 0, 1, 0);
      v(1, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 2,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 2,   0, 0, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 1, 1, 1, 0);
      v(0, 0, 0, 0, 1,   1, 0, 1, 1, 0);
      v(0, 0, 0, 0, 3,   0, 0, 0, 1, 0);
      run_vecs();
      blen = 16'd0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for a programmable clock divider. Converts start/stop commands and a half-period configuration from a valid/ready handshake into a glitch-free divided clock `o_clk` and a one-cycle rising-edge strobe `o_tick`. New divisors take effect only at period boundaries, so every emitted period is whole. Sits between the control logic (FSMs, register interface) and any logic clocked or enabled by slow derived clocks.

## Interface
- `COUNT_W`, 25: counter and half-period width in bits.
- `DEFAULT_HALF`, 12_500_000: half-period in input cycles after reset (2 Hz from 50 MHz).
- `i_clk` input 1: system clock; all logic is on the rising edge.
- `i_reset_n` input 1: asynchronous, active-low reset.
- `i_start` input 1: start request, sampled each cycle.
- `i_stop` input 1: stop request, sampled each cycle.
- `i_cfg_valid` input 1: configuration valid.
- `i_cfg_half` input COUNT_W: requested half-period in `i_clk` cycles.
- `o_cfg_ready` output 1: configuration can be accepted.
- `o_cfg_err` output 1: one-cycle pulse when a zero half-period is rejected.
- `o_clk` output 1: divided clock, registered.
- `o_tick` output 1: one-cycle pulse in the first cycle `o_clk` is 1.
- `o_busy` output 1: high in RUN and STOPPING.

## Operation
- Reset values: `o_clk`=0, `o_tick`=0, `o_cfg_ready`=1, `o_cfg_err`=0, `o_busy`=0. State is IDLE, counter is 0, and the active half equals `DEFAULT_HALF`. Any pending configuration is discarded. Reset asserted mid-run forces all of these immediately.
- **IDLE**: `o_clk` is held at 0 and the counter at 0.
  - `i_start`=1 and `i_stop`=0 moves the block to RUN.
- **RUN**: each cycle, if count == half-1, the block toggles `o_clk` and clears count; otherwise it increments count.
  - `i_stop`=1 with `o_clk`=0 moves to IDLE next cycle; count clears.
  - `i_stop`=1 with `o_clk`=1 moves to STOPPING.
- **STOPPING**: counts as in RUN. The toggle that drives `o_clk` to 0 moves the block to IDLE.
  - `i_start`=1 (with `i_stop`=0) returns to RUN without disturbing count or `o_clk`.
- Simultaneous `i_start` and `i_stop`: stop wins in every state. `i_start` in RUN and `i_stop` in IDLE are ignored.
- **Configuration handshake**: a transfer occurs when `i_cfg_valid` and `o_cfg_ready` are both 1.
  - Zero value: the transfer completes, the value is discarded, and `o_cfg_err`=1 the next cycle.
  - Non-zero value in IDLE: becomes the active half next cycle; `o_cfg_ready` stays 1.
  - Non-zero value in RUN or STOPPING: held as pending, and `o_cfg_ready` drops to 0. At the next falling toggle (`o_clk` 1→0), the pending value becomes the active half and count restarts at 0. `o_cfg_ready` returns to 1 the following cycle.
  - Entering IDLE with a config pending: the pending value is applied on that transition.
- Arithmetic: count is unsigned COUNT_W bits. The compare uses half-1 and never wraps, because half ≥ 1 is guaranteed. Half = 1 gives `o_clk` = `i_clk`/2.

## Timing
- Start asserted in cycle N (IDLE): RUN from N+1, count=0 at N+1. `o_clk` rises at N+1+half and falls at N+1+2·half. The period is 2·half cycles at 50% duty.
- `o_tick` is registered and coincides exactly with the first cycle of each `o_clk` high phase.
- `o_busy` is 1 from the first RUN cycle through the last STOPPING cycle. It is 0 in the cycle `o_clk` returns to 0 on the stop path.
- Stop never truncates a high phase. A low phase is truncated only by a stop issued in RUN.
- No combinational path exists from any input to any output.

## Configuration
- `CLK_DIV_CTRL_BURST_EN` defined:
  - Adds input `i_burst_len` (16 bits), sampled on the IDLE→RUN transition.
  - A non-zero value makes the block stop automatically after exactly that many complete periods: it enters IDLE on the falling toggle that ends the last period.
  - A value of 0 means run until `i_stop`.
  - A manual stop still applies.
- `CLK_DIV_CTRL_BURST_EN` undefined: the port is absent and the block runs until `i_stop`.

## Test plan
- Reset, then start with `DEFAULT_HALF` overridden to 4 → `o_clk` rises 4 cycles after RUN entry, period 8, one `o_tick` per rise, `o_busy`=1.
- Config 3 while running with half 4 → `o_cfg_ready`=0 until the next falling toggle. The following high and low phases are each 3 cycles, and no partial period appears.
- Config 0 in IDLE → `o_cfg_err` pulses for 1 cycle and the active half is unchanged.
- Stop during a high phase, half 5 → `o_clk` stays high for the full 5 cycles, then IDLE; `o_busy` falls with `o_clk`. Start and stop together → stop wins.
- `i_reset_n` low mid-run with a config pending → all outputs at reset values immediately. The pending config is discarded and the half reverts to the default.
- With `CLK_DIV_CTRL_BURST_EN`, burst_len 3 and half 2 → exactly 3 `o_tick` pulses, then IDLE after 12 cycles of RUN.
